// File: rtl/sl3_rx_pkg.sv
// Shared types for the SerialLite III RX deframer: FSM states, FIFO entry layout
// and a saturating increment used by the optional statistics counters.
package sl3_rx_pkg;

  localparam int SL3_DATA_W = 256;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BURST   = 3'd1,
    ABORT   = 3'd2,
    RESTART = 3'd3,
    DROP    = 3'd4
  } state_t;

  typedef struct packed {
    logic                  first;
    logic                  last;
    logic                  err;
    logic [SL3_DATA_W-1:0] data;
  } rx_entry_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sl3_rx_fifo.sv
// First-word-fall-through FIFO of rx_entry_t; the head entry is visible whenever
// count is non-zero and reads as all-zero when empty.
module sl3_rx_fifo
  import sl3_rx_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  rx_entry_t     wr_entry,
  input  logic          pop,
  output rx_entry_t     rd_entry,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  rx_entry_t     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the gated read below hides stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign count    = count_q;
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign rd_entry = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/seriallite3_rx_deframer.sv
// SerialLite III RX deframer: validates SOB/EOB framing, caps burst length and closes
// broken bursts with an error terminator. Define SL3_RX_DEFRAMER_STATS_EN for stat counters.
module seriallite3_rx_deframer
  import sl3_rx_pkg::*;
#(
  parameter int DATA_W          = SL3_DATA_W,
  parameter int FIFO_DEPTH      = 8,
  parameter int MAX_BURST_FLITS = 64
) (
  input  logic              interface_clock_rx,
  input  logic              interface_clock_reset_rx_n,
  input  logic              link_up_rx,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              rx_sob,
  input  logic              rx_eob,
  output logic              rx_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_first,
  output logic              out_last,
  output logic              out_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       stat_bursts_ok,
  output logic [31:0]       stat_framing_errs,
  output logic [31:0]       stat_dropped_flits,
  output state_t            dbg_state
);

  localparam int LW = $clog2(MAX_BURST_FLITS + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_t            state_q, state_d;
  logic [LW-1:0]     len_q, len_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              hold_eob_q, hold_eob_d;
  logic              hold_v_q, hold_v_d;
  logic              accept, push, pop, full, empty;
  logic              ferr_evt, drop_evt;
  logic [CW-1:0]     fifo_count;
  rx_entry_t         push_entry, head;

  assign rx_ready = (fifo_count < CW'(FIFO_DEPTH)) &&
                    (state_q inside {IDLE, BURST, DROP});
  assign accept   = rx_valid & rx_ready;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    hold_data_d = hold_data_q;
    hold_eob_d  = hold_eob_q;
    hold_v_d    = hold_v_q;
    push        = 1'b0;
    push_entry  = '0;
    ferr_evt    = 1'b0;
    drop_evt    = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        if (!link_up_rx) begin
          drop_evt = 1'b1;
        end else if (rx_sob) begin
          push             = 1'b1;
          push_entry.first = 1'b1;
          push_entry.last  = rx_eob;
          push_entry.data  = rx_data;
          state_d          = rx_eob ? IDLE : BURST;
          len_d            = rx_eob ? '0 : LW'(1);
        end else begin
          ferr_evt = 1'b1;
          drop_evt = 1'b1;
        end
      end
      BURST: begin
        // Link loss wins over any flit accepted in the same cycle.
        if (!link_up_rx) begin
          hold_v_d = 1'b0;
          drop_evt = accept;
          state_d  = ABORT;
        end else if (accept) begin
          if (rx_sob) begin
            hold_data_d = rx_data;
            hold_eob_d  = rx_eob;
            hold_v_d    = 1'b1;
            ferr_evt    = 1'b1;
            state_d     = ABORT;
          end else if (rx_eob) begin
            push            = 1'b1;
            push_entry.last = 1'b1;
            push_entry.data = rx_data;
            len_d           = '0;
            state_d         = IDLE;
          end else if (len_q + LW'(1) == LW'(MAX_BURST_FLITS)) begin
            push            = 1'b1;
            push_entry.last = 1'b1;
            push_entry.err  = 1'b1;
            push_entry.data = rx_data;
            ferr_evt        = 1'b1;
            len_d           = '0;
            state_d         = DROP;
          end else begin
            push            = 1'b1;
            push_entry.data = rx_data;
            len_d           = len_q + LW'(1);
          end
        end
      end
      ABORT: if (!full) begin
        push            = 1'b1;
        push_entry.last = 1'b1;
        push_entry.err  = 1'b1;
        state_d         = hold_v_q ? RESTART : IDLE;
      end
      RESTART: if (!full) begin
        push             = 1'b1;
        push_entry.first = 1'b1;
        push_entry.last  = hold_eob_q;
        push_entry.data  = hold_data_q;
        hold_v_d         = 1'b0;
        state_d          = hold_eob_q ? IDLE : BURST;
        len_d            = hold_eob_q ? '0 : LW'(1);
      end
      DROP: if (accept) begin
        if (rx_sob) begin
          push             = 1'b1;
          push_entry.first = 1'b1;
          push_entry.last  = rx_eob;
          push_entry.data  = rx_data;
          state_d          = rx_eob ? IDLE : BURST;
          len_d            = rx_eob ? '0 : LW'(1);
        end else begin
          drop_evt = 1'b1;
          if (rx_eob) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge interface_clock_rx or negedge interface_clock_reset_rx_n) begin
    if (!interface_clock_reset_rx_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      hold_data_q <= '0;
      hold_eob_q  <= 1'b0;
      hold_v_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      hold_data_q <= hold_data_d;
      hold_eob_q  <= hold_eob_d;
      hold_v_q    <= hold_v_d;
    end
  end

  assign pop = out_valid & out_ready;

  sl3_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (interface_clock_rx),
    .rst_n    (interface_clock_reset_rx_n),
    .push     (push),
    .wr_entry (push_entry),
    .pop      (pop),
    .rd_entry (head),
    .count    (fifo_count),
    .full     (full),
    .empty    (empty)
  );

  assign out_valid = ~empty;
  assign out_first = head.first;
  assign out_last  = head.last;
  assign out_err   = head.err;
  assign out_data  = head.data;
  assign dbg_state = state_q;

`ifdef SL3_RX_DEFRAMER_STATS_EN
  logic [31:0] ok_q, ok_d, ferr_q, ferr_d, drop_q, drop_d;

  always_comb begin
    ok_d   = (push && push_entry.last && !push_entry.err) ? sat_inc(ok_q) : ok_q;
    ferr_d = ferr_evt ? sat_inc(ferr_q) : ferr_q;
    drop_d = drop_evt ? sat_inc(drop_q) : drop_q;
  end

  always_ff @(posedge interface_clock_rx or negedge interface_clock_reset_rx_n) begin
    if (!interface_clock_reset_rx_n) begin
      ok_q   <= '0;
      ferr_q <= '0;
      drop_q <= '0;
    end else begin
      ok_q   <= ok_d;
      ferr_q <= ferr_d;
      drop_q <= drop_d;
    end
  end

  assign stat_bursts_ok     = ok_q;
  assign stat_framing_errs  = ferr_q;
  assign stat_dropped_flits = drop_q;
`else
  assign stat_bursts_ok     = '0;
  assign stat_framing_errs  = '0;
  assign stat_dropped_flits = '0;
`endif

endmodule

// File: tb/tb_seriallite3_rx_deframer.sv
// Directed bench for seriallite3_rx_deframer: hand-written expected entries in a queue,
// compared against every accepted output flit; stat expectations follow SL3_RX_DEFRAMER_STATS_EN.
`timescale 1ns/1ps
module tb_seriallite3_rx_deframer;
  import sl3_rx_pkg::*;

  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          link_up = 1'b1;
  logic [DW-1:0] rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_sob = 1'b0;
  logic          rx_eob = 1'b0;
  logic          rx_ready;
  logic [DW-1:0] out_data;
  logic          out_first, out_last, out_err, out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   stat_ok, stat_ferr, stat_drop;
  state_t        dbg_state;

  seriallite3_rx_deframer dut (
    .interface_clock_rx         (clk),
    .interface_clock_reset_rx_n (rst_n),
    .link_up_rx                 (link_up),
    .rx_data                    (rx_data),
    .rx_valid                   (rx_valid),
    .rx_sob                     (rx_sob),
    .rx_eob                     (rx_eob),
    .rx_ready                   (rx_ready),
    .out_data                   (out_data),
    .out_first                  (out_first),
    .out_last                   (out_last),
    .out_err                    (out_err),
    .out_valid                  (out_valid),
    .out_ready                  (out_ready),
    .stat_bursts_ok             (stat_ok),
    .stat_framing_errs          (stat_ferr),
    .stat_dropped_flits         (stat_drop),
    .dbg_state                  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [DW+2:0] exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  acc_cnt  = 0;
  bit  mon_en   = 1'b0;

  task automatic check(input string tag, input logic [DW+2:0] got, input logic [DW+2:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] st(input logic [31:0] v);
`ifdef SL3_RX_DEFRAMER_STATS_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  // scoreboard: inputs and outputs are stable between the driving edge and the next posedge
  always @(negedge clk) begin
    if (rst_n && rx_valid && rx_ready) acc_cnt++;
    if (mon_en && rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_out", 1, 0);
      else check("out_entry", {out_first, out_last, out_err, out_data}, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic exp_push(input logic f, input logic l, input logic e, input logic [DW-1:0] d);
    exp_q.push_back({f, l, e, d});
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_flit(input logic sob, input logic eob, input logic [DW-1:0] d);
    int cyc;
    cyc      = 0;
    rx_valid = 1'b1;
    rx_sob   = sob;
    rx_eob   = eob;
    rx_data  = d;
    while (1) begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (cyc > 300) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    rx_valid = 1'b0;
    rx_sob   = 1'b0;
    rx_eob   = 1'b0;
  endtask

  task automatic send_burst(input int n, input int base);
    for (int i = 0; i < n; i++) send_flit(i == 0, i == n - 1, DW'(base + i));
  endtask

  task automatic wait_drain();
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || out_valid) && cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("drain_done", (cyc < 1000), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_flags", {out_first, out_last, out_err}, 0);
    check("rst_out_data", out_data, 0);
    check("rst_state", dbg_state, IDLE);
    check("rst_stats", {stat_ok, stat_ferr, stat_drop}, 0);

    // 1: bursts of 1, 2 and 64 flits
    exp_push(1, 1, 0, 0);
    exp_push(1, 0, 0, 0);
    exp_push(0, 1, 0, 1);
    for (int i = 0; i < 64; i++) exp_push(i == 0, i == 63, 0, DW'(i));
    send_burst(1, 0);
    send_burst(2, 0);
    send_burst(64, 0);
    wait_drain();
    check("t1_bursts_ok", stat_ok, st(3));
    check("t1_framing", stat_ferr, st(0));

    // 2: stray flit in IDLE
    do_reset();
    send_flit(0, 0, DW'(8'hAA));
    repeat (3) @(posedge clk);
    #1;
    check("t2_no_output", out_valid, 0);
    check("t2_framing", stat_ferr, st(1));
    check("t2_dropped", stat_drop, st(1));

    // 3: unexpected sob inside a burst
    do_reset();
    exp_push(1, 0, 0, 1);
    exp_push(0, 0, 0, 2);
    exp_push(0, 0, 0, 3);
    exp_push(0, 1, 1, 0);
    exp_push(1, 0, 0, 4);
    exp_push(0, 1, 0, 5);
    send_flit(1, 0, 1);
    send_flit(0, 0, 2);
    send_flit(0, 0, 3);
    send_flit(1, 0, 4);
    send_flit(0, 1, 5);
    wait_drain();
    check("t3_framing", stat_ferr, st(1));
    check("t3_bursts_ok", stat_ok, st(1));

    // 4: 65-flit burst overruns the 64-flit limit
    do_reset();
    for (int i = 1; i <= 64; i++) exp_push(i == 1, i == 64, i == 64, DW'(i));
    send_burst(65, 1);
    check("t4_state_idle", dbg_state, IDLE);
    wait_drain();
    check("t4_dropped", stat_drop, st(1));
    check("t4_framing", stat_ferr, st(1));
    check("t4_bursts_ok", stat_ok, st(0));

    // 5: backpressure fills the FIFO
    do_reset();
    out_ready = 1'b0;
    acc_cnt   = 0;
    for (int i = 0; i < 12; i++) exp_push(i == 0, i == 11, 0, DW'(100 + i));
    fork
      send_burst(12, 100);
    join_none
    repeat (20) @(posedge clk);
    #1;
    check("t5_accepts", acc_cnt, 8);
    check("t5_rx_ready_low", rx_ready, 0);
    check("t5_out_valid", out_valid, 1);
    out_ready = 1'b1;
    wait fork;
    wait_drain();
    check("t5_bursts_ok", stat_ok, st(1));

    // 6a: link drop mid-burst
    do_reset();
    exp_push(1, 0, 0, 7);
    exp_push(0, 0, 0, 8);
    exp_push(0, 1, 1, 0);
    send_flit(1, 0, 7);
    send_flit(0, 0, 8);
    link_up = 1'b0;
    @(posedge clk);
    #1;
    link_up = 1'b1;
    wait_drain();
    check("t6a_state_idle", dbg_state, IDLE);
    check("t6a_bursts_ok", stat_ok, st(0));

    // 6b: async reset mid-burst
    do_reset();
    out_ready = 1'b0;
    send_flit(1, 0, 9);
    send_flit(0, 0, 10);
    send_flit(0, 0, 11);
    check("t6b_pre_valid", out_valid, 1);
    mon_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t6b_rst_valid", out_valid, 0);
    check("t6b_rst_flags", {out_first, out_last, out_err}, 0);
    check("t6b_rst_data", out_data, 0);
    check("t6b_rst_state", dbg_state, IDLE);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    mon_en    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t6b_fifo_empty", out_valid, 0);
    exp_push(1, 1, 0, 55);
    send_burst(1, 55);
    wait_drain();
    check("t6b_bursts_ok", stat_ok, st(1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
